data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words of storage (1 KiB).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the number of cycles from request acceptance to response; legal range is 1..7.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port mem_addr_in, input, 32 bits: byte address.
REQ-006 SHALL have port inst_pc_in, input, 32 bits: PC tag of the requesting instruction.
REQ-007 SHALL have port op_in, input, 4 bits: operation code, LB=7, LW=8, SB=9, SW=10.
REQ-008 SHALL have port store_data_in, input, 32 bits: store data; SB uses bits [7:0].
REQ-009 SHALL have port read_en_in, input, 1 bit: load request.
REQ-010 SHALL have port write_en_in, input, 1 bit: store request.
REQ-011 SHALL have port busy_out, output, 1 bit: responder is not accepting requests.
REQ-012 SHALL have port resp_valid_out, output, 1 bit: one-cycle response pulse.
REQ-013 SHALL have port resp_pc_out, output, 32 bits: PC tag echoed with the response.
REQ-014 SHALL have port load_data_out, output, 32 bits: load result; zero for stores.
REQ-015 SHALL have port resp_is_store_out, output, 1 bit: set when the response completes a store.
REQ-016 SHALL have port error_out, output, 1 bit: qualified by resp_valid_out; flags an illegal request.

Function
REQ-017 SHALL accept a request in a cycle where (read_en_in | write_en_in) && !busy_out; requests presented while busy_out=1 SHALL be ignored, and the requester SHALL hold them until accepted.
REQ-018 SHALL use an FSM with states IDLE, WAIT and RESP; on acceptance it SHALL move IDLE->WAIT, or IDLE->RESP when LATENCY=1.
REQ-019 SHALL reload a down-counter with LATENCY-1 on acceptance, decrement it in WAIT, and move WAIT->RESP when it reaches 1.
REQ-020 SHALL drive resp_valid_out=1 for exactly one cycle, in RESP, and then return RESP->IDLE.
REQ-021 SHALL hold busy_out=1 in WAIT and RESP, so the response arrives exactly LATENCY cycles after the accepting edge.
REQ-022 SHALL latch the address, op, PC and data at acceptance; input changes after acceptance SHALL NOT affect the response.
REQ-023 SHALL, for LW, return the aligned word at address bits [log2(DEPTH_WORDS)+1:2].
REQ-024 SHALL, for LB, return the byte selected by address [1:0] (little-endian), sign-extended to 32 bits.
REQ-025 SHALL, for SW, write the full word at the accepting edge.
REQ-026 SHALL, for SB, write only the selected byte at the accepting edge.
REQ-027 SHALL give a load accepted on the cycle after a store to the same address the new data.
REQ-028 SHALL ignore address bits above the array index range, so addresses wrap modulo DEPTH_WORDS*4.
REQ-029 SHALL treat these cases as errors, perform no memory write, and respond after LATENCY cycles with error_out=1 and load_data_out=0:
  - read_en_in and write_en_in both high;
  - op not matching the enable (for example read_en_in with SW);
  - op not in {7,8,9,10};
  - LW or SW with address [1:0] != 0.
REQ-030 SHALL drive load_data_out, resp_pc_out, resp_is_store_out and error_out to 0 whenever resp_valid_out=0.

Reset
REQ-031 SHALL, while rst is high, force state IDLE, counter 0, busy_out=0, resp_valid_out=0 and every other output to 0.
REQ-032 SHALL, on reset asserted mid-operation, abort the pending request with no response; a store already written SHALL remain written.
REQ-033 SHALL NOT clear the memory array on reset; contents are undefined until written.

Structure
REQ-034 SHALL take the op encodings LB/LW/SB/SW and the FSM state encoding from a shared package (mem_pkg) common with the load/store unit.
REQ-035 SHALL implement the storage as one sub-module, dmem_array: a synchronous-write, combinational-read byte-enabled RAM.

Verification
REQ-036 SHALL verify store/load round trip: SW addr 0x10 data 0xDEADBEEF, then LW addr 0x10 -> resp_valid exactly 2 cycles after acceptance, load_data=0xDEADBEEF, error=0.
REQ-037 SHALL verify byte access: after the word above, SB addr 0x13 data 0x80 -> LB 0x13 returns 0xFFFFFF80; LW 0x10 returns 0x80ADBEEF.
REQ-038 SHALL verify busy handling: a second LW is held during busy -> it is accepted only on the first cycle busy=0, and its resp_pc equals its own tag.
REQ-039 SHALL verify error cases: LW addr 0x12 -> error=1, data 0; read_en & write_en together -> error=1, memory unchanged.
REQ-040 SHALL verify reset mid-operation: assert rst during WAIT -> no resp_valid, busy=0 immediately; a following LW responds normally.
REQ-041 SHALL verify wrap-around: SW addr 0x400 data 0x1234 -> LW addr 0x0 returns 0x1234.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder and the load/store unit:
// op encodings, responder FSM states, latched request tag, request legality.
package mem_pkg;

   typedef enum logic [3:0] {
      OP_LB = 4'd7,
      OP_LW = 4'd8,
      OP_SB = 4'd9,
      OP_SW = 4'd10
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } mem_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  op;
      logic        err;
      logic        is_store;
   } mem_tag_t;

   // Illegal: both enables, op/enable mismatch, unknown op, misaligned word access.
   function automatic logic req_error(input logic rd, input logic wr,
                                      input logic [3:0] op, input logic [1:0] lo);
      logic is_ld, is_st, is_word;
      is_ld   = (op == OP_LB) || (op == OP_LW);
      is_st   = (op == OP_SB) || (op == OP_SW);
      is_word = (op == OP_LW) || (op == OP_SW);
      return (rd & wr) | (rd & ~is_ld) | (wr & ~is_st) | (is_word & (lo != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled word RAM: synchronous write, combinational read, never cleared.
module dmem_array #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [3:0][7:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[waddr][b] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory: accepts one load/store when idle, writes stores at
// the accepting edge, and answers with a one-cycle response LATENCY cycles later.
module data_mem_responder import mem_pkg::*; #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr_in,
   input  logic [31:0] inst_pc_in,
   input  logic [3:0]  op_in,
   input  logic [31:0] store_data_in,
   input  logic        read_en_in,
   input  logic        write_en_in,
   output logic        busy_out,
   output logic        resp_valid_out,
   output logic [31:0] resp_pc_out,
   output logic [31:0] load_data_out,
   output logic        resp_is_store_out,
   output logic        error_out
);

   localparam int AW = $clog2(DEPTH_WORDS);

   mem_state_e    state, state_nx;
   logic [2:0]    cnt;
   mem_tag_t      tag_q;
   logic [AW+1:0] addr_q;

   logic          accept, req_err, wr_ok;
   logic [3:0]    wr_be;
   logic [31:0]   wr_data, rd_word, load_val;
   logic [7:0]    rd_byte;
   logic          unused_addr;

   // Upper address bits alias onto the array, giving modulo wrap.
   assign unused_addr = ^mem_addr_in[31:AW+2];

   assign busy_out = (state != ST_IDLE);
   assign accept   = (read_en_in | write_en_in) & ~busy_out;
   assign req_err  = req_error(read_en_in, write_en_in, op_in, mem_addr_in[1:0]);
   assign wr_ok    = accept & write_en_in & ~req_err;
   assign wr_be    = (op_in == OP_SW) ? 4'hF : (4'b0001 << mem_addr_in[1:0]);
   assign wr_data  = (op_in == OP_SW) ? store_data_in : {4{store_data_in[7:0]}};

   dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
      .clk   (clk),
      .we    (wr_ok),
      .be    (wr_be),
      .waddr (mem_addr_in[AW+1:2]),
      .wdata (wr_data),
      .raddr (addr_q[AW+1:2]),
      .rdata (rd_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         tag_q  <= '0;
         addr_q <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cnt    <= 3'(LATENCY - 1);
            tag_q  <= '{pc: inst_pc_in, op: op_in, err: req_err,
                        is_store: write_en_in & ~req_err};
            addr_q <= mem_addr_in[AW+1:0];
         end else if (state == ST_WAIT) begin
            cnt <= cnt - 3'd1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: if (accept) state_nx = (LATENCY == 1) ? ST_RESP : ST_WAIT;
         ST_WAIT: if (cnt == 3'd1) state_nx = ST_RESP;
         ST_RESP: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Memory cannot change while busy, so reading with the latched address at
   // response time returns the same value as reading at acceptance.
   always_comb begin
      rd_byte = rd_word[7:0];
      case (addr_q[1:0])
         2'd1:    rd_byte = rd_word[15:8];
         2'd2:    rd_byte = rd_word[23:16];
         2'd3:    rd_byte = rd_word[31:24];
         default: rd_byte = rd_word[7:0];
      endcase
      load_val = '0;
      if (!tag_q.err) begin
         if (tag_q.op == OP_LW)      load_val = rd_word;
         else if (tag_q.op == OP_LB) load_val = {{24{rd_byte[7]}}, rd_byte};
      end
   end

   assign resp_valid_out    = (state == ST_RESP);
   assign resp_pc_out       = resp_valid_out ? tag_q.pc : '0;
   assign load_data_out     = resp_valid_out ? load_val : '0;
   assign resp_is_store_out = resp_valid_out & tag_q.is_store;
   assign error_out         = resp_valid_out & tag_q.err;

endmodule
